// File: rtl/elevator_scheduler_fsm.sv
// SCAN-order elevator car sequencer: latches floor calls, moves one floor per travel period, dwells with the door open.
// Optional build macro DOOR_REOPEN_EN: a call for the current floor while the door is open restarts the dwell.
module elevator_scheduler_fsm #(
    parameter int FLOORS       = 4,
    parameter int TRAVEL_TICKS = 50,
    parameter int DOOR_TICKS   = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] req_onehot,
    output logic [FLOORS-1:0] current_floor,
    output logic [FLOORS-1:0] pending,
    output logic              motor_up,
    output logic              motor_down,
    output logic              door_open,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    localparam int MAXT = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int CW   = $clog2(MAXT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_e;

    typedef struct packed {
        state_e st;
        logic   dir_up;
    } decision_t;

    state_e            state_q, state_d;
    logic              dir_up_q, dir_up_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FLOORS-1:0] floor_q, floor_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic [FLOORS-1:0] clear;
    logic              at_end;
    decision_t         dec;

    // Keep direction while calls lie ahead of the car, otherwise reverse; no calls at all means idle.
    function automatic decision_t scan(input logic [FLOORS-1:0] pend,
                                       input logic [FLOORS-1:0] floor,
                                       input logic              dir_up);
        decision_t         res;
        logic [FLOORS-1:0] below_m;
        logic [FLOORS-1:0] above_m;
        logic              a;
        logic              b;
        below_m    = floor - FLOORS'(1);
        above_m    = ~(below_m | floor);
        a          = |(pend & above_m);
        b          = |(pend & below_m);
        res.st     = IDLE;
        res.dir_up = dir_up;
        if (dir_up) begin
            if (a) begin
                res.st = MOVE_UP;
            end else if (b) begin
                res.st     = MOVE_DOWN;
                res.dir_up = 1'b0;
            end
        end else begin
            if (b) begin
                res.st = MOVE_DOWN;
            end else if (a) begin
                res.st     = MOVE_UP;
                res.dir_up = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;
        floor_d  = floor_q;
        dec      = '{st: IDLE, dir_up: dir_up_q};
        at_end   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|(pending_q & floor_q)) begin
                    state_d = DOOR_OPEN;
                end else begin
                    dec      = scan(pending_q, floor_q, dir_up_q);
                    state_d  = dec.st;
                    dir_up_d = dec.dir_up;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (cnt_q == CW'(TRAVEL_TICKS - 1)) begin
                    cnt_d  = '0;
                    at_end = (state_q == MOVE_UP) ? floor_q[FLOORS-1] : floor_q[0];
                    if (!at_end) begin
                        floor_d = (state_q == MOVE_UP) ? (floor_q << 1) : (floor_q >> 1);
                    end
                    if (|(pending_q & floor_d)) begin
                        state_d = DOOR_OPEN;
                    end else begin
                        dec      = scan(pending_q, floor_d, dir_up_q);
                        state_d  = dec.st;
                        dir_up_d = dec.dir_up;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DOOR_OPEN: begin
`ifdef DOOR_REOPEN_EN
                if (|(req_onehot & floor_q)) begin
                    cnt_d = '0;
                end else
`endif
                if (cnt_q == CW'(DOOR_TICKS - 1)) begin
                    cnt_d    = '0;
                    dec      = scan(pending_q & ~floor_q, floor_q, dir_up_q);
                    state_d  = dec.st;
                    dir_up_d = dec.dir_up;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // The floor being served is cleared every cycle the door is (or becomes) open, beating any same-cycle call.
        clear     = (state_d == DOOR_OPEN) ? floor_d : '0;
        pending_d = (pending_q | req_onehot) & ~clear;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dir_up_q  <= 1'b1;
            cnt_q     <= '0;
            floor_q   <= FLOORS'(1);
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            dir_up_q  <= dir_up_d;
            cnt_q     <= cnt_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
        end
    end

    assign current_floor = floor_q;
    assign pending       = pending_q;
    assign motor_up      = (state_q == MOVE_UP);
    assign motor_down    = (state_q == MOVE_DOWN);
    assign door_open     = (state_q == DOOR_OPEN);
    assign busy          = (state_q != IDLE);
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_elevator_scheduler_fsm.sv
// Bench for elevator_scheduler_fsm: a floor/direction/timer reference model predicts every cycle's outputs.
module tb_elevator_scheduler_fsm;

    localparam int FLOORS = 4;
    localparam int TRAVEL = 4;
    localparam int DOOR   = 3;
    localparam int W      = 12;

    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic              clk;
    logic              rst;
    logic [FLOORS-1:0] req_onehot;
    logic [FLOORS-1:0] current_floor;
    logic [FLOORS-1:0] pending;
    logic              motor_up;
    logic              motor_down;
    logic              door_open;
    logic              busy;
    logic [1:0]        state_dbg;

    elevator_scheduler_fsm #(
        .FLOORS      (FLOORS),
        .TRAVEL_TICKS(TRAVEL),
        .DOOR_TICKS  (DOOR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_onehot   (req_onehot),
        .current_floor(current_floor),
        .pending      (pending),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .door_open    (door_open),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // Clock and reset defaults
    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        req_onehot = '0;
        forever #5 clk = ~clk;
    end

    // Reference model: floor index, travel direction (+1/-1), call list, remaining ticks.
    int m_floor;
    int m_dir;
    int m_mode;
    int m_left;
    bit m_pend[FLOORS];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [W-1:0] exp_q[$];

    function automatic bit any_toward(int from, int d);
        for (int f = from + d; f >= 0 && f < FLOORS; f += d) begin
            if (m_pend[f]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic m_choose();
        if (any_toward(m_floor, m_dir)) begin
            m_mode = M_MOVE;
            m_left = TRAVEL;
        end else if (any_toward(m_floor, -m_dir)) begin
            m_dir  = -m_dir;
            m_mode = M_MOVE;
            m_left = TRAVEL;
        end else begin
            m_mode = M_IDLE;
        end
    endtask

    task automatic model_step(input logic [FLOORS-1:0] req, input logic r);
        bit reopen;
        if (r) begin
            m_floor = 0;
            m_dir   = 1;
            m_mode  = M_IDLE;
            m_left  = 0;
            for (int f = 0; f < FLOORS; f++) m_pend[f] = 1'b0;
            return;
        end
`ifdef DOOR_REOPEN_EN
        reopen = 1'b1;
`else
        reopen = 1'b0;
`endif
        case (m_mode)
            M_IDLE: begin
                if (m_pend[m_floor]) begin
                    m_mode = M_DOOR;
                    m_left = DOOR;
                end else begin
                    m_choose();
                end
            end
            M_MOVE: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor += m_dir;
                    if (m_pend[m_floor]) begin
                        m_mode = M_DOOR;
                        m_left = DOOR;
                    end else begin
                        m_choose();
                    end
                end
            end
            default: begin
                if (reopen && req[m_floor]) begin
                    m_left = DOOR;
                end else begin
                    m_left--;
                    if (m_left == 0) m_choose();
                end
            end
        endcase
        for (int f = 0; f < FLOORS; f++) begin
            if (req[f]) m_pend[f] = 1'b1;
        end
        if (m_mode == M_DOOR) m_pend[m_floor] = 1'b0;
    endtask

    function automatic logic [W-1:0] model_outputs();
        logic [FLOORS-1:0] cf;
        logic [FLOORS-1:0] pv;
        cf = '0;
        pv = '0;
        cf[m_floor] = 1'b1;
        for (int f = 0; f < FLOORS; f++) pv[f] = m_pend[f];
        return {cf, pv, (m_mode == M_MOVE && m_dir > 0), (m_mode == M_MOVE && m_dir < 0),
                (m_mode == M_DOOR), (m_mode != M_IDLE)};
    endfunction

    // Driver: apply inputs for one edge, predict the post-edge outputs, queue them for the monitor.
    task automatic drive(input logic [FLOORS-1:0] req, input logic r);
        logic [W-1:0] e;
        rst        = r;
        req_onehot = req;
        model_step(req, r);
        e = model_outputs();
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n;
        n = 0;
        drive('0, 1'b0);
        while (m_mode != M_IDLE && n < budget) begin
            drive('0, 1'b0);
            n++;
        end
        checks++;
        if (m_mode != M_IDLE) begin
            errors++;
            $display("FAIL %s timeout: model still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic run_until_moving_from(input string name, input int floor_idx, input int budget);
        int n;
        n = 0;
        while (!(m_mode == M_MOVE && m_floor == floor_idx) && n < budget) begin
            drive('0, 1'b0);
            n++;
        end
        checks++;
        if (!(m_mode == M_MOVE && m_floor == floor_idx)) begin
            errors++;
            $display("FAIL %s timeout: car not moving from floor index %0d after %0d cycles", name, floor_idx, budget);
        end
    endtask

    // Monitor: one expected record per clock edge, compared at the following falling edge.
    initial begin
        logic [W-1:0] got;
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                cyc++;
                e   = exp_q.pop_front();
                got = {current_floor, pending, motor_up, motor_down, door_open, busy};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got cf=%b pend=%b up/dn/door/busy=%b expected cf=%b pend=%b up/dn/door/busy=%b",
                             cyc, got[11:8], got[7:4], got[3:0], e[11:8], e[7:4], e[3:0]);
                end
                checks++;
                if (!$onehot(current_floor)) begin
                    errors++;
                    $display("FAIL onehot cyc=%0d got current_floor=%b required exactly one bit set", cyc, current_floor);
                end
                checks++;
                if (!$onehot0({motor_up, motor_down, door_open})) begin
                    errors++;
                    $display("FAIL exclusive cyc=%0d got up/dn/door=%b required at most one set", cyc,
                             {motor_up, motor_down, door_open});
                end
            end
        end
    end

    initial begin
        logic [FLOORS-1:0] rq;
        // Reset
        drive('0, 1'b1);
        drive('0, 1'b1);

        // Reset mid-move while travelling up out of floor 2
        drive(4'b1000, 1'b0);
        run_until_moving_from("mid_move", 1, 20);
        drive('0, 1'b0);
        drive('0, 1'b1);
        repeat (3) drive('0, 1'b0);

        // Same-floor call at floor 1
        drive(4'b0001, 1'b0);
        run_until_idle("same_floor", 20);
        repeat (2) drive('0, 1'b0);

        // Run to floor 4
        drive(4'b1000, 1'b0);
        run_until_idle("run_to_top", 40);

        // Calls for 3 and 1 while between floors 2 and 3 going up
        drive('0, 1'b1);
        drive(4'b1000, 1'b0);
        run_until_moving_from("sweep", 1, 20);
        drive(4'b0101, 1'b0);
        run_until_idle("sweep", 80);

        // Own-floor call on the second door cycle at floor 2
        drive('0, 1'b1);
        drive(4'b0010, 1'b0);
        while (m_mode != M_DOOR && cyc < 5000) drive('0, 1'b0);
        drive('0, 1'b0);
        drive(4'b0010, 1'b0);
        run_until_idle("door_call", 20);

        // Reversal at the top floor with dir still up
        drive('0, 1'b1);
        drive(4'b1000, 1'b0);
        run_until_idle("to_top", 40);
        drive(4'b0001, 1'b0);
        run_until_idle("reverse", 40);

        // Randomised calls with rare resets
        for (int i = 0; i < 1500; i++) begin
            rq = ($urandom_range(0, 99) < 15) ? FLOORS'($urandom_range(1, 15)) : '0;
            drive(rq, ($urandom_range(0, 399) == 0));
        end
        run_until_idle("drain", 200);

        rst        = 1'b0;
        req_onehot = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected records left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
